// File: rtl/keccak_pkg.sv
// Shared definitions for the Keccak lane loader and its neighbours.
//   LANE_W    : bits per lane
//   NUM_LANES : lanes per state (5x5 matrix)
//   STATE_W   : bits per full state
//   state_t   : loader FSM encoding
//   lane_index: flat lane number for matrix coordinate (x, y)
package keccak_pkg;

  localparam int unsigned LANE_W    = 64;
  localparam int unsigned NUM_LANES = 25;
  localparam int unsigned STATE_W   = LANE_W * NUM_LANES;

  typedef enum logic [1:0] {
    StFill  = 2'd0,
    StStart = 2'd1,
    StWait  = 2'd2
  } state_t;

  // x runs fastest, then y.
  function automatic logic [4:0] lane_index(input int unsigned x, input int unsigned y);
    return 5'(x + 5 * y);
  endfunction

endpackage

// File: rtl/lane_state_loader.sv
// Assembles a Keccak state from a stream of 64-bit lanes and hands it to the
// permutation core.
//   clk, rst     : clock (rising edge), asynchronous active-high reset
//   in_valid     : source offers in_data this cycle
//   in_data      : lane value, index order x + 5*y
//   in_ready     : loader accepts a lane this cycle
//   state_out    : assembled state, lane i at [LANE_W*i +: LANE_W]
//   perm_start   : one-cycle start pulse to the permutation core
//   perm_done    : completion from the permutation core
//   busy         : permutation in flight (START and WAIT)
//   lane_idx     : index of the next lane to be written
//   blocks_done  : completed permutations, wrapping counter
module lane_state_loader #(
  parameter int unsigned LANE_W    = keccak_pkg::LANE_W,
  parameter int unsigned NUM_LANES = keccak_pkg::NUM_LANES,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic [LANE_W-1:0]           in_data,
  output logic                        in_ready,
  output logic [LANE_W*NUM_LANES-1:0] state_out,
  output logic                        perm_start,
  input  logic                        perm_done,
  output logic                        busy,
  output logic [4:0]                  lane_idx,
  output logic [CNT_W-1:0]            blocks_done
);

  import keccak_pkg::*;

  state_t                             state_q, state_d;
  logic [NUM_LANES-1:0][LANE_W-1:0]   lanes_q, lanes_d;
  logic [4:0]                         idx_q, idx_d;
  logic [CNT_W-1:0]                   cnt_q, cnt_d;
  // Registered so that ready stays low while reset is held and rises on the
  // first edge after release.
  logic                               rdy_q, rdy_d;
  logic                               xfer;
  logic                               last_lane;

  assign xfer      = in_valid & rdy_q & (state_q == StFill);
  assign last_lane = (idx_q == 5'(NUM_LANES - 1));

  always_comb begin
    state_d = state_q;
    lanes_d = lanes_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StFill: begin
        if (xfer) begin
          for (int i = 0; i < int'(NUM_LANES); i++) begin
            if (idx_q == 5'(i)) lanes_d[i] = in_data;
          end
          if (last_lane) begin
            idx_d   = 5'd0;
            state_d = StStart;
          end else begin
            idx_d = idx_q + 5'd1;
          end
        end
      end
      StStart: state_d = StWait;
      StWait: begin
        // Leaving on the first sampled done makes a held done count once.
        if (perm_done) begin
          cnt_d   = cnt_q + 1'b1;
          state_d = StFill;
        end
      end
      default: state_d = StFill;
    endcase
    rdy_d = (state_d == StFill);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StFill;
      lanes_q <= '0;
      idx_q   <= 5'd0;
      cnt_q   <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lanes_q <= lanes_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      rdy_q   <= rdy_d;
    end
  end

  assign in_ready    = rdy_q;
  assign state_out   = lanes_q;
  assign perm_start  = (state_q == StStart);
  assign busy        = (state_q != StFill);
  assign lane_idx    = idx_q;
  assign blocks_done = cnt_q;

endmodule

// File: tb/tb_lane_state_loader.sv
// Directed bench for lane_state_loader with a start-pulse scoreboard.
module tb_lane_state_loader;
  import keccak_pkg::*;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic [63:0]  in_data;
  logic         in_ready;
  logic [1599:0] state_out;
  logic         perm_start;
  logic         perm_done;
  logic         busy;
  logic [4:0]   lane_idx;
  logic [15:0]  blocks_done;

  lane_state_loader #(
    .LANE_W   (64),
    .NUM_LANES(25),
    .CNT_W    (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .state_out  (state_out),
    .perm_start (perm_start),
    .perm_done  (perm_done),
    .busy       (busy),
    .lane_idx   (lane_idx),
    .blocks_done(blocks_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int start_cnt = 0;
  logic prev_start = 1'b0;

  logic [63:0]   model [25];
  int            model_idx;
  int            exp_blocks;
  logic [1599:0] exp_q [$];

  function automatic logic [1599:0] pack_model();
    logic [1599:0] v;
    for (int i = 0; i < 25; i++) v[64*i +: 64] = model[i];
    return v;
  endfunction

  function automatic int first_diff(input logic [1599:0] a, input logic [1599:0] b);
    for (int i = 0; i < 25; i++) if (a[64*i +: 64] !== b[64*i +: 64]) return i;
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic chk_state(input string tag);
    logic [1599:0] expv;
    int            d;
    expv = pack_model();
    d    = first_diff(state_out, expv);
    n_cmp++;
    assert (d < 0) else begin
      n_err++;
      $error("FAIL %s: lane %0d observed %h expected %h", tag, d,
             state_out[64*d +: 64], expv[64*d +: 64]);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 25; i++) model[i] = '0;
    model_idx = 0;
  endtask

  // Offers one lane and waits (bounded) for it to be accepted.
  task automatic send_lane(input logic [63:0] d);
    int w;
    in_valid = 1'b1;
    in_data  = d;
    w = 0;
    while (in_ready !== 1'b1 && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    n_cmp++;
    assert (w < 50) else begin
      n_err++;
      $error("FAIL send_timeout: observed in_ready %b expected 1", in_ready);
    end
    chk("lane_idx_pre", 64'(lane_idx), 64'(model_idx));
    @(posedge clk); #1;
    model[model_idx] = d;
    model_idx = (model_idx + 1) % 25;
    if (model_idx == 0) exp_q.push_back(pack_model());
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
    chk("idle_lane_idx", 64'(lane_idx), 64'(model_idx));
    chk_state("idle_state");
  endtask

  // Scoreboard: each start pulse must carry the state queued at the 25th lane.
  always @(negedge clk) begin
    if (perm_start === 1'b1) begin
      logic [1599:0] expv;
      int            d;
      start_cnt++;
      n_cmp++;
      assert (prev_start !== 1'b1) else begin
        n_err++;
        $error("FAIL start_width: observed start on consecutive cycles expected single");
      end
      n_cmp++;
      if (exp_q.size() == 0) begin
        assert (0) else begin
          n_err++;
          $error("FAIL start_unexpected: observed perm_start expected none");
        end
      end else begin
        expv = exp_q.pop_front();
        d    = first_diff(state_out, expv);
        assert (d < 0) else begin
          n_err++;
          $error("FAIL start_state: lane %0d observed %h expected %h", d,
                 state_out[64*d +: 64], expv[64*d +: 64]);
        end
      end
    end
    prev_start = perm_start;
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    perm_done = 1'b0;
    model_clear();
    exp_blocks = 0;

    // Reset
    #12;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk_state("rst_state");
    chk("rst_lane_idx", 64'(lane_idx), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    #11 rst = 1'b0;
    @(posedge clk); #1;
    chk("rel_in_ready", 64'(in_ready), 64'd1);
    chk("rel_blocks", 64'(blocks_done), 64'd0);

    // Back-to-back fill
    for (int i = 0; i < 25; i++) send_lane(64'd1 << i);
    chk("b2b_start", 64'(perm_start), 64'd1);
    chk("b2b_busy", 64'(busy), 64'd1);
    chk("b2b_idx_wrap", 64'(lane_idx), 64'd0);
    chk("b2b_lane7", state_out[64*lane_index(2, 1) +: 64], 64'h80);
    chk("b2b_lane24", state_out[64*lane_index(4, 4) +: 64], 64'h0100_0000);

    // WAIT backpressure
    in_valid = 1'b1;
    in_data  = 64'hDEAD;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      chk("wait_in_ready", 64'(in_ready), 64'd0);
      chk("wait_start", 64'(perm_start), 64'd0);
      chk_state("wait_state");
    end
    perm_done = 1'b1;
    @(posedge clk); #1;
    perm_done = 1'b0;
    exp_blocks++;
    chk("done_blocks", 64'(blocks_done), 64'(exp_blocks));
    chk("done_busy", 64'(busy), 64'd0);
    chk("done_in_ready", 64'(in_ready), 64'd1);
    send_lane(64'hDEAD);
    chk("dead_lane0", state_out[63:0], 64'hDEAD);

    // Source stalls, with a spurious done during FILL
    for (int i = 1; i < 25; i++) begin
      send_lane({$urandom, $urandom});
      if (i == 5) perm_done = 1'b1;
      if (i % 2 == 1) idle(2);
      perm_done = 1'b0;
      if (i == 5) chk("spurious_blocks", 64'(blocks_done), 64'(exp_blocks));
    end
    chk("stall_start", 64'(perm_start), 64'd1);
    in_valid = 1'b0;

    // Long done, raised already during START
    perm_done = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
    end
    perm_done = 1'b0;
    exp_blocks++;
    chk("long_done_blocks", 64'(blocks_done), 64'(exp_blocks));
    chk("long_done_ready", 64'(in_ready), 64'd1);
    chk("start_count_2", 64'(start_cnt), 64'd2);

    // Reset mid-fill
    for (int i = 0; i < 12; i++) send_lane({$urandom, $urandom});
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    model_clear();
    exp_blocks = 0;
    chk("mid_rst_idx", 64'(lane_idx), 64'd0);
    chk_state("mid_rst_state");
    chk("mid_rst_ready", 64'(in_ready), 64'd0);
    chk("mid_rst_blocks", 64'(blocks_done), 64'd0);
    @(posedge clk); #3;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_no_start", 64'(start_cnt), 64'd2);
    for (int i = 0; i < 25; i++) send_lane({$urandom, $urandom});
    idle(3);
    chk("final_start_count", 64'(start_cnt), 64'd3);
    perm_done = 1'b1;
    @(posedge clk); #1;
    perm_done = 1'b0;
    exp_blocks++;
    chk("final_blocks", 64'(blocks_done), 64'(exp_blocks));
    chk("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
